// File: rtl/branch_predictor_if.sv
// Pipeline-facing bundle of the branch predictor: F/D lookup, M-stage training and status.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_if #(
   parameter int unsigned GHR_BITS = 6
);
   logic [31:0]         lookup_pc;
   logic                stallD;
   logic                flushD;
   logic                branchD;
   logic                pred_takeD;
   logic [GHR_BITS-1:0] ghr_snapD;
   logic                update_en;
   logic [31:0]         update_pc;
   logic [GHR_BITS-1:0] update_ghr;
   logic                update_taken;
   logic                update_mispred;
   logic                ready;
   logic [31:0]         stat_branches;
   logic [31:0]         stat_mispred;

   modport master (
      output lookup_pc, stallD, flushD, branchD,
      output update_en, update_pc, update_ghr, update_taken, update_mispred,
      input  pred_takeD, ghr_snapD, ready, stat_branches, stat_mispred
   );

   modport slave (
      input  lookup_pc, stallD, flushD, branchD,
      input  update_en, update_pc, update_ghr, update_taken, update_mispred,
      output pred_takeD, ghr_snapD, ready, stat_branches, stat_mispred
   );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal / gshare branch direction predictor: PHT of 2-bit saturating counters walked to
// CTR_INIT after reset, registered D-stage prediction, speculative GHR with mispredict repair.
module branch_predictor #(
   parameter int unsigned ENTRIES  = 64,
   parameter int unsigned GHR_BITS = 6,
   parameter int unsigned MODE     = 1,
   parameter logic [1:0]  CTR_INIT = 2'b01
) (
   input logic clk,
   input logic rst,
   branch_predictor_if.slave bp
);
   localparam int unsigned IDX = $clog2(ENTRIES);

   typedef logic [IDX-1:0] idx_t;
   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e              state_q;
   idx_t                walk_q;
   logic [GHR_BITS-1:0] ghr_q, ghr_d;
   logic                pred_q;
   logic [GHR_BITS-1:0] snap_q;
   logic [31:0]         branches_q, mispred_q;
   logic [1:0]          pht_q [ENTRIES];

   logic                run;
   idx_t                lookup_idx, update_idx;
   logic [1:0]          ctr_old, ctr_d;

   function automatic idx_t pht_index(input logic [31:0] pc, input logic [GHR_BITS-1:0] h);
      idx_t pc_idx;
      pc_idx = pc[IDX+1:2];
      if (MODE == 1) return pc_idx ^ idx_t'(h);
      return pc_idx;
   endfunction

   // Widening by one bit first keeps the shift legal for GHR_BITS == 1.
   function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] h, input logic b);
      logic [GHR_BITS:0] t;
      t = {h, b};
      return t[GHR_BITS-1:0];
   endfunction

   assign run        = (state_q == S_RUN);
   assign lookup_idx = pht_index(bp.lookup_pc, ghr_q);
   assign update_idx = pht_index(bp.update_pc, bp.update_ghr);
   assign ctr_old    = pht_q[update_idx];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      ctr_d = ctr_old;
      if (bp.update_taken) begin
         if (ctr_old != 2'd3) ctr_d = ctr_old + 2'd1;
      end else begin
         if (ctr_old != 2'd0) ctr_d = ctr_old - 2'd1;
      end
   end

   // Repair is evaluated last so it overrides a same-cycle speculative shift.
   always_comb begin
      ghr_d = ghr_q;
      if (MODE == 1 && run) begin
         if (bp.branchD && !bp.stallD && !bp.flushD) ghr_d = shift_in(ghr_q, pred_q);
         if (bp.update_en && bp.update_mispred)      ghr_d = shift_in(bp.update_ghr, bp.update_taken);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_INIT;
         walk_q     <= '0;
         ghr_q      <= '0;
         pred_q     <= 1'b0;
         snap_q     <= '0;
         branches_q <= '0;
         mispred_q  <= '0;
      end else begin
         ghr_q <= ghr_d;
         if (state_q == S_INIT) begin
            walk_q <= walk_q + idx_t'(1);
            if (walk_q == idx_t'(ENTRIES - 1)) state_q <= S_RUN;
         end
         if (bp.flushD) begin
            pred_q <= 1'b0;
            snap_q <= '0;
         end else if (!bp.stallD) begin
            pred_q <= run & pht_q[lookup_idx][1];
            snap_q <= ghr_q;
         end
         if (run && bp.update_en) begin
            branches_q <= branches_q + 32'd1;
            if (bp.update_mispred) mispred_q <= mispred_q + 32'd1;
         end
      end
   end

   // NOTE: the PHT has no reset term; the init walk rewrites every entry after reset instead.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state_q == S_INIT)  pht_q[walk_q]     <= CTR_INIT;
         else if (bp.update_en)  pht_q[update_idx] <= ctr_d;
      end
   end

   assign bp.pred_takeD    = pred_q;
   assign bp.ghr_snapD     = snap_q;
   assign bp.ready         = run;
   assign bp.stat_branches = branches_q;
   assign bp.stat_mispred  = mispred_q;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{bp.lookup_pc[31:IDX+2], bp.lookup_pc[1:0],
                             bp.update_pc[31:IDX+2], bp.update_pc[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a gshare and a bimodal instance share one stimulus stream and are
// compared each cycle with an arithmetic reference model, plus directed corner-case sequences.
module tb_branch_predictor;
   localparam int ENTRIES = 64;
   localparam int GHR     = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [31:0]    lookup_pc, update_pc;
   logic           stallD, flushD, branchD;
   logic           update_en, update_taken, update_mispred;
   logic [GHR-1:0] update_ghr;

   branch_predictor_if #(.GHR_BITS(GHR)) ifg ();
   branch_predictor_if #(.GHR_BITS(GHR)) ifb ();

   assign ifg.lookup_pc = lookup_pc;       assign ifb.lookup_pc = lookup_pc;
   assign ifg.stallD = stallD;             assign ifb.stallD = stallD;
   assign ifg.flushD = flushD;             assign ifb.flushD = flushD;
   assign ifg.branchD = branchD;           assign ifb.branchD = branchD;
   assign ifg.update_en = update_en;       assign ifb.update_en = update_en;
   assign ifg.update_pc = update_pc;       assign ifb.update_pc = update_pc;
   assign ifg.update_ghr = update_ghr;     assign ifb.update_ghr = update_ghr;
   assign ifg.update_taken = update_taken; assign ifb.update_taken = update_taken;
   assign ifg.update_mispred = update_mispred;
   assign ifb.update_mispred = update_mispred;

   branch_predictor #(.ENTRIES(ENTRIES), .GHR_BITS(GHR), .MODE(1), .CTR_INIT(2'b01)) dut_g (
      .clk(clk), .rst(rst), .bp(ifg));
   branch_predictor #(.ENTRIES(ENTRIES), .GHR_BITS(GHR), .MODE(0), .CTR_INIT(2'b01)) dut_b (
      .clk(clk), .rst(rst), .bp(ifb));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model; index 0 = bimodal instance, index 1 = gshare instance.
   int          m_ctr  [2][ENTRIES];
   int          m_ghr  [2];
   int          m_pred [2];
   int          m_snap [2];
   int          m_init_left = 0;
   int unsigned m_br = 0, m_mp = 0;

   function automatic int midx(input int mode, input logic [31:0] pc, input int h);
      int base;
      base = int'((pc >> 2) % ENTRIES);
      return (mode == 1) ? (base ^ h) : base;
   endfunction

   function automatic int hist(input int h, input int b);
      return ((h << 1) | b) % (1 << GHR);
   endfunction

   task automatic model_edge();
      int look, upd, np, nghr;
      if (!rst) begin
         m_init_left = ENTRIES;
         m_br = 0;
         m_mp = 0;
         for (int m = 0; m < 2; m++) begin
            m_ghr[m] = 0; m_pred[m] = 0; m_snap[m] = 0;
         end
      end else if (m_init_left > 0) begin
         m_init_left--;
         for (int m = 0; m < 2; m++) begin
            m_pred[m] = 0; m_snap[m] = 0;
            if (m_init_left == 0)
               for (int i = 0; i < ENTRIES; i++) m_ctr[m][i] = 1;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            look = midx(m, lookup_pc, m_ghr[m]);
            upd  = midx(m, update_pc, int'(update_ghr));
            np   = (m_ctr[m][look] >= 2) ? 1 : 0;
            nghr = m_ghr[m];
            if (m == 1) begin
               if (branchD && !stallD && !flushD) nghr = hist(m_ghr[m], m_pred[m]);
               if (update_en && update_mispred)   nghr = hist(int'(update_ghr), int'(update_taken));
            end
            if (flushD) begin
               m_pred[m] = 0; m_snap[m] = 0;
            end else if (!stallD) begin
               m_pred[m] = np; m_snap[m] = m_ghr[m];
            end
            if (update_en)
               m_ctr[m][upd] = update_taken ? ((m_ctr[m][upd] < 3) ? m_ctr[m][upd] + 1 : 3)
                                            : ((m_ctr[m][upd] > 0) ? m_ctr[m][upd] - 1 : 0);
            m_ghr[m] = nghr;
         end
         if (update_en) begin
            m_br++;
            if (update_mispred) m_mp++;
         end
      end
   endtask

   task automatic compare_all();
      check("g.pred",   32'(ifg.pred_takeD),  32'(m_pred[1]));
      check("g.snap",   32'(ifg.ghr_snapD),   32'(m_snap[1]));
      check("g.ready",  32'(ifg.ready),       32'(m_init_left == 0));
      check("g.stat_b", ifg.stat_branches,    m_br);
      check("g.stat_m", ifg.stat_mispred,     m_mp);
      check("b.pred",   32'(ifb.pred_takeD),  32'(m_pred[0]));
      check("b.snap",   32'(ifb.ghr_snapD),   32'(m_snap[0]));
      check("b.ready",  32'(ifb.ready),       32'(m_init_left == 0));
      check("b.stat_b", ifb.stat_branches,    m_br);
      check("b.stat_m", ifb.stat_mispred,     m_mp);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      stallD = 0; flushD = 0; branchD = 0;
      update_en = 0; update_taken = 0; update_mispred = 0; update_ghr = '0;
      update_pc = 32'h0040_0000; lookup_pc = 32'h0040_0000;
   endtask

   typedef struct {
      logic upd;
      logic taken;
      logic exp_pred;
      int   exp_br;
   } vec_t;

   vec_t tbl [10];
   int   ready_at;

   initial begin
      // Counter at pc 0x00400010 starts at 01; each row's prediction reflects the pre-update value.
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 2};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 2};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 3};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 4};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 5};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 6};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 6};
      tbl[8] = '{1'b1, 1'b1, 1'b0, 7};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 7};

      idle_inputs();
      rst = 0;
      tick();
      tick();
      check("rst.ready", 32'(ifg.ready), 0);
      check("rst.pred",  32'(ifg.pred_takeD), 0);
      check("rst.snap",  32'(ifg.ghr_snapD), 0);
      check("rst.stat",  ifg.stat_branches, 0);

      // Init walk with updates hammered every INIT cycle.
      rst = 1;
      ready_at = -1;
      update_taken = 1; update_mispred = 1;
      for (int c = 1; c <= 70; c++) begin
         update_en = (c <= ENTRIES);
         update_pc = $urandom();
         tick();
         if (ifg.ready === 1'b1 && ready_at < 0) ready_at = c;
      end
      check("init.ready_cycle", 32'(ready_at), 64);
      check("init.stat_b", ifg.stat_branches, 0);
      check("init.stat_m", ifb.stat_mispred, 0);
      idle_inputs();
      for (int i = 0; i < ENTRIES; i++) begin
         lookup_pc = 32'h0040_0000 | (32'(i) << 2);
         tick();
         check("init.pred_b", 32'(ifb.pred_takeD), 0);
         check("init.pred_g", 32'(ifg.pred_takeD), 0);
      end

      // Saturating counter + same-index read-before-write (bimodal instance).
      lookup_pc = 32'h0040_0010;
      update_pc = 32'h0040_0010;
      for (int r = 0; r < 10; r++) begin
         update_en = tbl[r].upd;
         update_taken = tbl[r].taken;
         tick();
         check($sformatf("tbl[%0d].pred", r), 32'(ifb.pred_takeD), 32'(tbl[r].exp_pred));
         check($sformatf("tbl[%0d].br", r), ifb.stat_branches, 32'(tbl[r].exp_br));
      end
      idle_inputs();

      // Train entries 0,1,3,7 to strongly taken, then drive speculative history.
      for (int k = 0; k < 4; k++) begin
         update_en = 1; update_taken = 1; update_ghr = '0;
         update_pc = 32'h0040_0000 | (32'((1 << k) - 1) << 2);
         tick();
         tick();
      end
      idle_inputs();
      lookup_pc = 32'h0040_0000;
      tick();
      check("ghr.pred0", 32'(ifg.pred_takeD), 1);
      branchD = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("ghr.pred_spec", 32'(ifg.pred_takeD), 1);
      end
      branchD = 0;
      tick();
      check("ghr.shift3", 32'(ifg.ghr_snapD), 32'h07);
      branchD = 1;
      update_en = 1; update_mispred = 1; update_ghr = 6'b000001; update_taken = 0;
      update_pc = 32'h0040_0000;
      tick();
      idle_inputs();
      tick();
      check("ghr.repair", 32'(ifg.ghr_snapD), 32'h02);

      // Stall holds, flush beats stall.
      lookup_pc = 32'h0040_0004;
      tick();
      check("hold.pred0", 32'(ifg.pred_takeD), 1);
      check("hold.snap0", 32'(ifg.ghr_snapD), 2);
      stallD = 1; branchD = 1; lookup_pc = 32'h0040_0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold.pred", 32'(ifg.pred_takeD), 1);
         check("hold.snap", 32'(ifg.ghr_snapD), 2);
      end
      flushD = 1;
      tick();
      check("flush.pred", 32'(ifg.pred_takeD), 0);
      check("flush.snap", 32'(ifg.ghr_snapD), 0);
      idle_inputs();

      // Reset in the middle of the walk restarts it from zero.
      rst = 0;
      tick();
      rst = 1;
      update_en = 1; update_taken = 1;
      for (int c = 0; c < 20; c++) tick();
      check("midwalk.ready", 32'(ifg.ready), 0);
      rst = 0;
      tick();
      rst = 1;
      ready_at = -1;
      for (int c = 1; c <= 70; c++) begin
         update_en = (c <= ENTRIES);
         tick();
         if (ifb.ready === 1'b1 && ready_at < 0) ready_at = c;
      end
      check("midwalk.ready_cycle", 32'(ready_at), 64);
      check("midwalk.stat", ifb.stat_branches, 0);
      idle_inputs();

      // Randomized traffic against the model, with rare resets.
      for (int n = 0; n < 3000; n++) begin
         rst            = ($urandom_range(0, 999) != 0);
         stallD         = ($urandom_range(0, 3) == 0);
         flushD         = ($urandom_range(0, 9) == 0);
         branchD        = $urandom_range(0, 1);
         update_en      = $urandom_range(0, 1);
         update_taken   = $urandom_range(0, 1);
         update_mispred = ($urandom_range(0, 3) == 0);
         update_ghr     = GHR'($urandom());
         lookup_pc      = $urandom();
         update_pc      = ($urandom_range(0, 1) == 1) ? lookup_pc : $urandom();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
